// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: row/column lines, clear, and decoded key outputs.
// The master drives the keypad rows and clear; the slave is the scanner.
interface keypad_scanner_if;
  logic [3:0]  ROW;
  logic        CLR;
  logic [3:0]  COL;
  logic [3:0]  KEY_CODE;
  logic        KEY_VALID;
  logic        KEY_DOWN;
  logic [31:0] DIGITS;

  modport master (
    output ROW, CLR,
    input  COL, KEY_CODE, KEY_VALID, KEY_DOWN, DIGITS
  );

  modport slave (
    input  ROW, CLR,
    output COL, KEY_CODE, KEY_VALID, KEY_DOWN, DIGITS
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debounce and digit history.
// One column is driven low per slot; rows are sampled once at slot end.
module keypad_scanner #(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 4
) (
  input logic             CLK,
  input logic             RST,
  keypad_scanner_if.slave kp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  // Indexed by {row, col}
  localparam logic [3:0] KMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } state_t;

  state_t        state, state_n;
  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] slot;
  logic [1:0]    c;
  logic [1:0]    hits, hits_n;
  logic [3:0]    fcode, fcode_n;
  logic [3:0]    cnt, cnt_n;
  logic [3:0]    cand, cand_n;
  logic          fire, gone;
  logic          slot_end, frame_end;
  logic [3:0]    act;
  logic [2:0]    n_act;
  logic [1:0]    r_idx;
  logic [1:0]    nsat;
  logic [2:0]    tot;
  logic          f_one;
  logic          match;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_down;
  logic [31:0]   digits;

  assign slot_end  = (slot == SLOT_MAX);
  assign frame_end = slot_end && (c == 2'd3);
  assign act       = ~row_s2;

  always_comb begin
    n_act = 3'd0;
    r_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (act[i]) begin
        n_act = n_act + 3'd1;
        r_idx = i[1:0];
      end
    end
  end

  // Saturating hit count: 0 = NONE, 1 = ONE, 2 = MULTI
  always_comb begin
    nsat    = (n_act > 3'd1) ? 2'd2 : n_act[1:0];
    tot     = {1'b0, hits} + {1'b0, nsat};
    hits_n  = (tot > 3'd1) ? 2'd2 : tot[1:0];
    fcode_n = (n_act == 3'd1) ? KMAP[{r_idx, c}] : fcode;
  end

  assign f_one = (hits_n == 2'd1);
  assign match = f_one && (fcode_n == cand);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_s1 <= 4'h0;
      row_s2 <= 4'h0;
      slot   <= '0;
      c      <= 2'd0;
      hits   <= 2'd0;
      fcode  <= 4'h0;
    end else begin
      row_s1 <= kp.ROW;
      row_s2 <= row_s1;
      slot   <= slot_end ? '0 : slot + CW'(1);
      if (slot_end) begin
        c     <= c + 2'd1;
        hits  <= frame_end ? 2'd0 : hits_n;
        fcode <= frame_end ? 4'h0 : fcode_n;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    fire    = 1'b0;
    gone    = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (f_one) begin
            cand_n = fcode_n;
            if (DEB == 4'd1) begin
              state_n = HELD;
              cnt_n   = 4'd0;
              fire    = 1'b1;
            end else begin
              state_n = PRESS_CHK;
              cnt_n   = 4'd1;
            end
          end
        end
        PRESS_CHK: begin
          if (match) begin
            if (cnt + 4'd1 >= DEB) begin
              state_n = HELD;
              cnt_n   = 4'd0;
              fire    = 1'b1;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end
        end
        HELD: begin
          if (!match) begin
            if (DEB == 4'd1) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
              gone    = 1'b1;
            end else begin
              state_n = REL_CHK;
              cnt_n   = 4'd1;
            end
          end
        end
        REL_CHK: begin
          if (match) begin
            state_n = HELD;
            cnt_n   = 4'd0;
          end else if (cnt + 4'd1 >= DEB) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            gone    = 1'b1;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cand      <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      digits    <= 32'h0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_valid <= fire;
      if (fire) begin
        key_code <= cand;
      end
      if (fire) begin
        key_down <= 1'b1;
      end else if (gone) begin
        key_down <= 1'b0;
      end
      // Clear wins over history but keeps a key confirmed this cycle
      if (kp.CLR) begin
        digits <= fire ? {28'h0, cand} : 32'h0;
      end else if (fire) begin
        digits <= {digits[27:0], cand};
      end
    end
  end

  assign kp.COL       = ~(4'b0001 << c);
  assign kp.KEY_CODE  = key_code;
  assign kp.KEY_VALID = key_valid;
  assign kp.KEY_DOWN  = key_down;
  assign kp.DIGITS    = digits;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Key changes land just after a frame boundary so every frame is clean.
module tb_keypad_scanner;

  logic        CLK;
  logic        RST;
  logic [15:0] keys;
  int          checks;
  int          errors;
  int          vcount;
  int          v0;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .kp  (kp.slave)
  );

  always #5 CLK = ~CLK;

  // Pressed key at {r,c} pulls row r low while column c is driven low
  always_comb begin
    kp.ROW = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kp.COL[c]) begin
          kp.ROW[r] = 1'b0;
        end
      end
    end
  end

  always @(posedge CLK) begin
    if (kp.KEY_VALID === 1'b1) begin
      vcount++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame_wait(input int n);
    repeat (16 * n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"},   32'(kp.COL), 32'hE);
    chk({tag, "_code"},  32'(kp.KEY_CODE), 32'h0);
    chk({tag, "_valid"}, 32'(kp.KEY_VALID), 32'h0);
    chk({tag, "_down"},  32'(kp.KEY_DOWN), 32'h0);
    chk({tag, "_dig"},   kp.DIGITS, 32'h0);
  endtask

  task automatic tap(input int bitn);
    keys = 16'h0;
    keys[bitn] = 1'b1;
    frame_wait(3);
    keys = 16'h0;
    frame_wait(3);
  endtask

  initial begin
    CLK    = 1'b0;
    RST    = 1'b0;
    keys   = 16'h0;
    kp.CLR = 1'b0;
    checks = 0;
    errors = 0;
    vcount = 0;

    repeat (3) @(negedge CLK);
    chk_reset_vals("rst");

    RST = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k == 2)  chk("col0", 32'(kp.COL), 32'hE);
      if (k == 6)  chk("col1", 32'(kp.COL), 32'hD);
      if (k == 10) chk("col2", 32'(kp.COL), 32'hB);
      if (k == 14) chk("col3", 32'(kp.COL), 32'h7);
      if (k == 16) chk("colwrap", 32'(kp.COL), 32'hE);
    end
    chk("idle_novalid", 32'(vcount), 32'd0);

    keys[5] = 1'b1;
    frame_wait(2);
    chk("k5_valid", 32'(kp.KEY_VALID), 32'h1);
    chk("k5_code",  32'(kp.KEY_CODE), 32'h5);
    chk("k5_dig",   kp.DIGITS, 32'h5);
    chk("k5_down",  32'(kp.KEY_DOWN), 32'h1);
    frame_wait(1);
    chk("k5_pulse1", 32'(kp.KEY_VALID), 32'h0);
    chk("k5_count",  32'(vcount), 32'd1);
    chk("k5_held",   32'(kp.KEY_DOWN), 32'h1);
    keys = 16'h0;
    frame_wait(1);
    chk("k5_relchk", 32'(kp.KEY_DOWN), 32'h1);
    frame_wait(1);
    chk("k5_up", 32'(kp.KEY_DOWN), 32'h0);

    kp.CLR = 1'b1;
    @(negedge CLK);
    kp.CLR = 1'b0;
    chk("clr1", kp.DIGITS, 32'h0);
    repeat (15) @(negedge CLK);

    v0 = vcount;
    tap(0);
    tap(1);
    tap(3);
    chk("hold_code", 32'(kp.KEY_CODE), 32'hA);
    tap(12);
    chk("seq_dig",   kp.DIGITS, 32'h12A0);
    chk("seq_count", 32'(vcount - v0), 32'd4);

    v0 = vcount;
    keys[10] = 1'b1;
    frame_wait(1);
    keys = 16'h0;
    frame_wait(3);
    chk("bounce_cnt", 32'(vcount - v0), 32'd0);
    chk("bounce_dig", kp.DIGITS, 32'h12A0);

    v0 = vcount;
    keys[2]  = 1'b1;
    keys[14] = 1'b1;
    frame_wait(3);
    chk("multi_cnt", 32'(vcount - v0), 32'd0);
    keys[14] = 1'b0;
    frame_wait(2);
    chk("k3_valid", 32'(kp.KEY_VALID), 32'h1);
    chk("k3_code",  32'(kp.KEY_CODE), 32'h3);
    chk("k3_dig",   kp.DIGITS, 32'h12A03);
    keys = 16'h0;
    frame_wait(3);

    keys[7] = 1'b1;
    frame_wait(1);
    repeat (15) @(posedge CLK);
    @(negedge CLK);
    kp.CLR = 1'b1;
    @(negedge CLK);
    kp.CLR = 1'b0;
    chk("clrkey_valid", 32'(kp.KEY_VALID), 32'h1);
    chk("clrkey_dig",   kp.DIGITS, 32'hB);
    keys = 16'h0;
    frame_wait(3);

    v0 = vcount;
    keys[4] = 1'b1;
    frame_wait(3);
    keys = 16'h0;
    keys[6] = 1'b1;
    frame_wait(3);
    chk("swap_wait", 32'(vcount - v0), 32'd1);
    chk("swap_code", 32'(kp.KEY_CODE), 32'h4);
    frame_wait(1);
    chk("swap_valid", 32'(kp.KEY_VALID), 32'h1);
    chk("swap_newcode", 32'(kp.KEY_CODE), 32'h6);
    chk("swap_dig", kp.DIGITS, 32'hB46);
    keys = 16'h0;
    frame_wait(3);

    keys[11] = 1'b1;
    frame_wait(1);
    v0 = vcount;
    RST = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    chk("midrst_nopulse", 32'(vcount - v0), 32'd0);
    frame_wait(1);
    chk("kc_early", 32'(kp.KEY_VALID), 32'h0);
    frame_wait(1);
    chk("kc_valid", 32'(kp.KEY_VALID), 32'h1);
    chk("kc_code",  32'(kp.KEY_CODE), 32'hC);
    chk("kc_dig",   kp.DIGITS, 32'hC);
    keys = 16'h0;
    frame_wait(3);
    kp.CLR = 1'b1;
    @(negedge CLK);
    kp.CLR = 1'b0;
    chk("clr_final", kp.DIGITS, 32'h0);
    chk("total_pulses", 32'(vcount), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, is the clock cycles per column slot (1 ms at 100 MHz); legal minimum 4.
REQ-002 Parameter DEBOUNCE, default 4, is the consecutive identical full-scan frames needed to confirm a press or release; legal range 1..15.
REQ-003 CLK  input  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 ROW  input  4  keypad row lines, active-low (pulled up externally), asynchronous to CLK.
REQ-006 CLR  input  1  synchronous clear of DIGITS, active-high.
REQ-007 COL  output  4  keypad column drive; exactly one bit is low at a time, the rest are high.
REQ-008 KEY_CODE  output  4  hex code of the last confirmed key.
REQ-009 KEY_VALID  output  1  single-cycle pulse on each confirmed press.
REQ-010 KEY_DOWN  output  1  high while a confirmed key is held.
REQ-011 DIGITS  output  32  eight-nibble entry history; nibble 0 = newest; ready for the 8-digit seven-segment driver.

Function
REQ-012 ROW SHALL pass through a two-flop synchronizer before any use.
REQ-013 A slot counter SHALL count 0..SCAN_DIV-1 and wrap; column index c (0..3) SHALL advance on wrap and wrap from 3 to 0.
REQ-014 COL SHALL be 4'b1111 with bit c cleared.
REQ-015 Synchronized ROW SHALL be sampled only on counter value SCAN_DIV-1 of each slot.
REQ-016 A frame (columns 0..3) SHALL classify as NONE (zero active rows), ONE (exactly one active row/column intersection, code latched), or MULTI (more than one).
REQ-017 Key map by (row r, col c): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D.
REQ-018 The FSM SHALL have states IDLE, PRESS_CHK, HELD, and REL_CHK, and SHALL evaluate only at frame end.
REQ-019 IDLE: a ONE frame -> PRESS_CHK, candidate = code, count = 1; NONE or MULTI stays in IDLE.
REQ-020 PRESS_CHK: a ONE frame with the same code increments count; on reaching DEBOUNCE -> HELD. NONE, MULTI, or a different code -> IDLE with count cleared.
REQ-021 On entry to HELD: KEY_CODE = candidate, KEY_VALID high for exactly one cycle, KEY_DOWN = 1, and DIGITS <= {DIGITS[27:0], candidate} in the same cycle.
REQ-022 HELD: a ONE frame with the same code stays in HELD with no repeat pulse; any other frame -> REL_CHK, count = 1.
REQ-023 REL_CHK: a non-matching frame increments count; on reaching DEBOUNCE -> IDLE with KEY_DOWN = 0. A matching ONE frame -> HELD with no new KEY_VALID.
REQ-024 With DEBOUNCE=1, a transition SHALL occur at the first qualifying frame end.
REQ-025 A different key pressed while a key is HELD SHALL register only after a full release-to-IDLE and a new press check.
REQ-026 CLR SHALL zero DIGITS the next cycle; when CLR coincides with a KEY_VALID shift, DIGITS SHALL become {28'h0, code}.
REQ-027 KEY_CODE SHALL hold its value until the next confirmed press.

Reset
REQ-028 With RST low: COL = 4'b1110, KEY_CODE = 0, KEY_VALID = 0, KEY_DOWN = 0, DIGITS = 0, FSM = IDLE, and all counters and the synchronizer = 0.
REQ-029 Reset asserted mid-frame or mid-debounce SHALL abort the operation with no KEY_VALID pulse; after release, scanning SHALL restart at column 0, counter 0.

Verification
REQ-030 SCAN_DIV=4, DEBOUNCE=2, no key -> COL cycles 1110,1101,1011,0111 every 4 cycles; KEY_VALID never asserted.
REQ-031 Key '5' (r1,c1) held for 3 frames -> one KEY_VALID pulse at the end of frame 2, KEY_CODE=4'h5, DIGITS=32'h00000005, KEY_DOWN=1.
REQ-032 Press sequence 1,2,A,0 (each press/release ≥3 frames) -> DIGITS=32'h000012A0 and exactly 4 KEY_VALID pulses.
REQ-033 Key '9' present for 1 frame only (bounce) -> no KEY_VALID; DIGITS unchanged.
REQ-034 Keys '3' and 'E' held simultaneously -> MULTI frames; no KEY_VALID; after releasing 'E', '3' registers after 2 frames.
REQ-035 RST low during PRESS_CHK of 'C', then released with key still held -> outputs at reset values, then KEY_VALID with code C after 2 full frames; CLR pulse -> DIGITS=0.
